// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants: word type, schedule window size,
// sigma rotate/shift amounts and the message-schedule FSM states.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned SCHED_WIN = 16;
  localparam int unsigned SIG0_R1   = 7;
  localparam int unsigned SIG0_R2   = 18;
  localparam int unsigned SIG0_SH   = 3;
  localparam int unsigned SIG1_R1   = 17;
  localparam int unsigned SIG1_R2   = 19;
  localparam int unsigned SIG1_SH   = 10;

  typedef enum logic {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } sched_state_t;

  function automatic word_t ror32(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the message source, the schedule expander and the round stage.
// Optional out_idx lane is present when SHA256_SCHED_IDX_EN is defined.
interface sha256_msg_sched_if;
  import sha256_pkg::*;

  // A word transfers on a rising edge where valid && ready; valid never waits on
  // ready, and payload is held stable while valid is high and ready is low.
  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  logic  out_last;
`ifdef SHA256_SCHED_IDX_EN
  logic [5:0] out_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
`endif

endinterface

// File: rtl/sha256_msg_sched_sig0.sv
// SHA-256 small sigma-0: ROR7 ^ ROR18 ^ SHR3, purely combinational.
module sig0
  import sha256_pkg::*;
(
  input  word_t req_data0,
  output word_t resp_data
);

  assign resp_data = ror32(req_data0, SIG0_R1) ^ ror32(req_data0, SIG0_R2)
                   ^ (req_data0 >> SIG0_SH);

endmodule

// File: rtl/sha256_msg_sched_sig1.sv
// SHA-256 small sigma-1: ROR17 ^ ROR19 ^ SHR10, purely combinational.
module sig1
  import sha256_pkg::*;
(
  input  word_t req_data0,
  output word_t resp_data
);

  assign resp_data = ror32(req_data0, SIG1_R1) ^ ror32(req_data0, SIG1_R2)
                   ^ (req_data0 >> SIG1_SH);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, streams W[0..NUM_ROUNDS-1].
// Define SHA256_SCHED_IDX_EN to add the out_idx lane (schedule index of out_data).
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  sha256_msg_sched_if.slave   bus,
  output sched_state_t        dbg_state
);

  localparam logic [5:0] LOAD_LAST = 6'(SCHED_WIN - 1);
  localparam logic [5:0] OUT_LAST  = 6'(NUM_ROUNDS - 1);

  sched_state_t state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  word_t        win_q [SCHED_WIN];
  word_t        win_d [SCHED_WIN];

  word_t sig0_w1;
  word_t sig1_w14;
  word_t new_word;
  logic  in_hs;
  logic  out_hs;
  logic  last;

  sig0 u_sig0 (.req_data0(win_q[1]),  .resp_data(sig0_w1));
  sig1 u_sig1 (.req_data0(win_q[14]), .resp_data(sig1_w14));

  assign new_word = sig1_w14 + win_q[9] + sig0_w1 + win_q[0];

  // Every output is a flop or a decode of flops, so out_ready never reaches out_data.
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EXPAND);
  assign bus.out_data  = win_q[0];
  assign last          = (state_q == EXPAND) && (cnt_q == OUT_LAST);
  assign bus.out_last  = last;
`ifdef SHA256_SCHED_IDX_EN
  assign bus.out_idx   = (state_q == EXPAND) ? cnt_q : 6'd0;
`endif
  assign dbg_state     = state_q;

  assign in_hs  = (state_q == LOAD)   && bus.in_valid;
  assign out_hs = (state_q == EXPAND) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (flush) begin
      // The window is left as-is; the next load overwrites all 16 entries.
      state_d = LOAD;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_hs) begin
            for (int i = 0; i < SCHED_WIN - 1; i++) win_d[i] = win_q[i+1];
            win_d[SCHED_WIN-1] = bus.in_data;
            if (cnt_q == LOAD_LAST) begin
              cnt_d   = 6'd0;
              state_d = EXPAND;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        EXPAND: begin
          if (out_hs) begin
            for (int i = 0; i < SCHED_WIN - 1; i++) win_d[i] = win_q[i+1];
            win_d[SCHED_WIN-1] = new_word;
            if (last) begin
              cnt_d   = 6'd0;
              state_d = LOAD;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_d = LOAD;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 6'd0;
      for (int i = 0; i < SCHED_WIN; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < SCHED_WIN; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: known-answer table, backpressure,
// garbage input during expansion, flush, async reset and randomized blocks.
module tb_sha256_msg_sched;
  import sha256_pkg::*;

  localparam int NR = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  sched_state_t dbg_state;

  sha256_msg_sched_if bus();

  sha256_msg_sched #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  word_t       cap [NR];
  int          n_hs;
  int          n_cyc;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Reference schedule straight from the SHA-256 definition.
  function automatic word_t rr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void model(input word_t b [16], output word_t w [NR]);
    word_t full [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) full[t] = b[t];
      else full[t] = (rr(full[t-2], 17) ^ rr(full[t-2], 19) ^ (full[t-2] >> 10))
                   + full[t-7]
                   + (rr(full[t-15], 7) ^ rr(full[t-15], 18) ^ (full[t-15] >> 3))
                   + full[t-16];
    end
    for (int t = 0; t < NR; t++) w[t] = full[t];
  endfunction

  // kind 0: "abc" padded block, 1: all zero, 2: single 1 in W0, else random
  function automatic void build(input int kind, output word_t b [16]);
    for (int i = 0; i < 16; i++) b[i] = '0;
    case (kind)
      0: begin b[0] = 32'h6162_6380; b[15] = 32'h0000_0018; end
      1: ;
      2: b[0] = 32'h0000_0001;
      default: for (int i = 0; i < 16; i++) b[i] = $urandom();
    endcase
  endfunction

  task automatic load_block(input word_t b [16]);
    int    idx = 0;
    int    guard = 0;
    word_t w [NR];
    model(b, w);
    for (int t = 0; t < NR; t++) exp_q.push_back(w[t]);
    while (idx < 16 && guard < 200) begin
      @(negedge clk);
      guard++;
      check("load_in_ready", 32'(bus.in_ready), 32'd1);
      check("load_out_valid", 32'(bus.out_valid), 32'd0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = b[idx];
      if (bus.in_valid && bus.in_ready) idx++;
    end
    if (idx < 16) check("load_timeout", idx, 16);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: ready always 1, 1: toggle 1-0-1-0, 2: random
  task automatic collect(input int mode, input int stop_after, input bit garbage);
    int          t = 0;
    int          cyc = 0;
    bit          held = 1'b0;
    bit          first = 1'b1;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    logic [5:0]  pi = '0;
    while (t < stop_after && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      check(first ? "first_out_latency" : "expand_out_valid", 32'(bus.out_valid), 32'd1);
      first = 1'b0;
      check("expand_in_ready", 32'(bus.in_ready), 32'd0);
      if (held) begin
        check("hold_data", bus.out_data, pd);
        check("hold_last", 32'(bus.out_last), 32'(pl));
`ifdef SHA256_SCHED_IDX_EN
        check("hold_idx", 32'(bus.out_idx), 32'(pi));
`endif
      end
      bus.in_valid = garbage;
      bus.in_data  = $urandom();
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 1);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
        else check($sformatf("out_data_w%0d", t), bus.out_data, exp_q.pop_front());
        check($sformatf("out_last_w%0d", t), 32'(bus.out_last), 32'(t == NR - 1));
`ifdef SHA256_SCHED_IDX_EN
        check($sformatf("out_idx_w%0d", t), 32'(bus.out_idx), t);
`endif
        cap[t] = bus.out_data;
        t++;
        held = 1'b0;
      end else begin
        held = bus.out_valid;
        pd   = bus.out_data;
        pl   = bus.out_last;
`ifdef SHA256_SCHED_IDX_EN
        pi   = bus.out_idx;
`endif
      end
    end
    if (t < stop_after) check("collect_timeout", t, stop_after);
    n_hs  = t;
    n_cyc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (stop_after == NR) begin
      @(negedge clk);
      check("end_out_valid", 32'(bus.out_valid), 32'd0);
      check("end_in_ready", 32'(bus.in_ready), 32'd1);
      check("end_state", 32'(dbg_state), 32'(LOAD));
      check("handshake_count", n_hs, NR);
      if (mode == 0) check("one_word_per_cycle", n_cyc, NR);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, bus.out_data, 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'(LOAD));
`ifdef SHA256_SCHED_IDX_EN
    check({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    word_t b [16];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{"abc_w0",  0, 0,  32'h6162_6380};
    tbl[1] = '{"abc_w15", 0, 15, 32'h0000_0018};
    tbl[2] = '{"abc_w16", 0, 16, 32'h6162_6380};
    tbl[3] = '{"abc_w17", 0, 17, 32'h000F_0000};
    tbl[4] = '{"zero_w63", 1, 63, 32'h0000_0000};
    tbl[5] = '{"one_w16", 2, 16, 32'h0000_0001};
    tbl[6] = '{"one_w1",  2, 1,  32'h0000_0000};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Known-answer table, full throughput
    for (int i = 0; i < 7; i++) begin
      build(tbl[i].kind, b);
      load_block(b);
      collect(0, NR, 1'b0);
      check(tbl[i].name, cap[tbl[i].idx], tbl[i].exp);
    end

    // "abc" with out_ready toggling
    build(0, b);
    load_block(b);
    collect(1, NR, 1'b0);

    // Garbage offered during expansion, then a back-to-back independent block
    build(3, b);
    load_block(b);
    collect(2, NR, 1'b1);
    build(3, b);
    load_block(b);
    collect(0, NR, 1'b0);

    // Flush after 20 handshakes with a same-cycle out_ready
    build(0, b);
    load_block(b);
    collect(0, 20, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_state", 32'(dbg_state), 32'(LOAD));
    exp_q.delete();
    load_block(b);
    collect(0, NR, 1'b0);
    check("flush_reload_w0", cap[0], 32'h6162_6380);

    // Async reset between clock edges mid-expansion
    build(0, b);
    load_block(b);
    collect(0, 10, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b0;
    exp_q.delete();
    load_block(b);
    collect(0, NR, 1'b0);

    // Randomized blocks with random backpressure
    for (int r = 0; r < 5; r++) begin
      build(3, b);
      load_block(b);
      collect(int'($urandom_range(0, 2)), NR, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
